ifu_pc_gen: RTL and testbench
=============================

# ifu_pc_gen

Parametrised fetch-address generator: the next generation of the IFU next-PC logic. It holds the architectural fetch PC in a register, predicts the next PC through a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and accepts redirects and training updates from the branch-resolution stage. It sits at the front of the IFU and drives the instruction-memory address every cycle.

## Interface
- `RESET_PC`, 32'h00003000, PC value loaded on reset.
- `BTB_ENTRIES`, 16, number of BTB entries; power of two, 2..256.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `stall` input 1: hold the current PC (pipeline freeze).
- `redirect_valid` input 1: resolved flow differs from the prediction; load `redirect_pc`.
- `redirect_pc` input 32: correct next fetch address.
- `update_valid` input 1: train the BTB with one resolved control-flow instruction.
- `update_pc` input 32: address of the resolved instruction.
- `update_taken` input 1: resolved direction.
- `update_target` input 32: resolved target; used only when taken.
- `pc` output 32: current fetch address, registered.
- `pred_taken` output 1: BTB predicts taken for `pc`.
- `pred_target` output 32: predicted next PC for `pc`.

## Operation
- IDX = log2(BTB_ENTRIES). Index = `pc[IDX+1:2]`; tag = `pc[31:IDX+2]`. Each entry holds valid, tag, target[31:2], and ctr[1:0].
- Lookup (combinational on `pc`): hit = valid && tag match. `pred_taken` = hit && ctr[1]. `pred_target` = pred_taken ? {target, 2'b00} : `pc` + 4 (32-bit wrap; 32'hFFFFFFFC + 4 = 0).
- Next-PC priority, evaluated per cycle: `redirect_valid` → `redirect_pc`; else `stall` → `pc`; else `pred_target`. Bits [1:0] of the loaded value are forced to 00.
- Training, when `update_valid`, at the entry indexed by `update_pc`:
  - Hit, taken: ctr saturating +1 (max 11); target ← `update_target`.
  - Hit, not taken: ctr saturating −1 (min 00). Entry stays valid.
  - Miss, taken: allocate. Valid = 1; tag, target written; ctr = 10 (weakly taken). A valid entry with a different tag is overwritten.
  - Miss, not taken: no change.
- `stall` does not block training. `redirect_valid` and `update_valid` in the same cycle are independent; both take effect.
- The block has no misprediction detection of its own. The resolution stage compares its result against the `pred_*` values it carried down the pipeline and asserts `redirect_valid`.

## Timing
- Reset (asynchronous assert, synchronous release): `pc` = RESET_PC; all valid bits cleared; ctr = 00. In the first cycle after reset, `pred_taken` = 0 and `pred_target` = RESET_PC + 4.
- Reset asserted mid-operation discards any in-flight update or redirect for that edge.
- `pc` updates on each rising edge. `pred_*` have zero latency from `pc` and the BTB state.
- A training write is visible to lookups from the next cycle. A lookup and an update to the same index in one cycle see the old contents.
- Redirect latency: `redirect_pc` appears on `pc` one edge after `redirect_valid` is sampled.

## Configuration
- `IFU_BTB_EN` defined: BTB storage and training are present, as described above.
- `IFU_BTB_EN` undefined: no BTB storage. `pred_taken` is tied to 0 and `pred_target` = `pc` + 4. Update ports are ignored. Redirect, stall, and reset behave identically.

## Test plan
- Reset with RESET_PC = 32'h00003000, then three free-running cycles → `pc` = 3000, 3004, 3008, 300C; `pred_taken` = 0 throughout.
- `stall` = 1 and `redirect_valid` = 1 with `redirect_pc` = 32'h00004003 in the same cycle → next `pc` = 32'h00004000. Then `stall` alone for 2 cycles → `pc` holds at 4000.
- Train `update_pc` = 3010, taken, target 3100. When `pc` reaches 3010 → `pred_taken` = 1 and next `pc` = 3100. Train the same PC not-taken twice → ctr = 00 and `pred_taken` = 0 at 3010.
- Aliasing with 16 entries: train 3010 → 3100, then train 3050 → 3200 (same index, different tag) → 3010 misses and 3050 hits with target 3200.
- Update to the index of the current `pc` in the same cycle → that cycle's `pred_taken` reflects the old entry; the new entry is visible next cycle. `pc` = 32'hFFFFFFFC with no hit → next `pc` = 0.
- With `IFU_BTB_EN` undefined, rerun the training scenario → `pred_taken` stays 0 and `pc` increments by 4.

Source files
------------

// File: rtl/ifu_pc_gen.sv
// Fetch-address generator: registered fetch PC with next-PC selection from a
// direct-mapped BTB with 2-bit counters. Define IFU_BTB_EN to build the BTB.
module ifu_pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  output logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  // Handshake: redirect_valid and update_valid are single-cycle qualifiers with
  // no ready; the block always consumes them on the edge where they are high.

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;

  logic [31:0] pc_plus4;
  logic [31:0] pc_next;

  assign pc_plus4 = pc + 32'd4;

`ifdef IFU_BTB_EN
  logic             btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [29:0]      btb_target [BTB_ENTRIES];
  logic [1:0]       btb_ctr    [BTB_ENTRIES];

  logic [IDX-1:0]   rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic [IDX-1:0]   wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  logic             unused_btb;

  assign rd_idx = pc[IDX+1:2];
  assign rd_tag = pc[31:IDX+2];
  assign rd_hit = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);

  assign wr_idx = update_pc[IDX+1:2];
  assign wr_tag = update_pc[31:IDX+2];
  assign wr_hit = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);

  assign pred_taken  = rd_hit && btb_ctr[rd_idx][1];
  assign pred_target = pred_taken ? {btb_target[rd_idx], 2'b00} : pc_plus4;

  // Lookup reads the arrays combinationally, so a same-cycle write is only
  // seen by the lookup after the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b00;
      end
    end else if (update_valid) begin
      if (wr_hit) begin
        if (update_taken) begin
          if (btb_ctr[wr_idx] != 2'b11) btb_ctr[wr_idx] <= btb_ctr[wr_idx] + 2'd1;
          btb_target[wr_idx] <= update_target[31:2];
        end else if (btb_ctr[wr_idx] != 2'b00) begin
          btb_ctr[wr_idx] <= btb_ctr[wr_idx] - 2'd1;
        end
      end else if (update_taken) begin
        // Allocation replaces whatever lived at this index, weakly taken.
        btb_valid[wr_idx]  <= 1'b1;
        btb_tag[wr_idx]    <= wr_tag;
        btb_target[wr_idx] <= update_target[31:2];
        btb_ctr[wr_idx]    <= 2'b10;
      end
    end
  end

  assign unused_btb = ^{update_pc[1:0], update_target[1:0], redirect_pc[1:0]};
`else
  logic unused_upd;

  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
  assign unused_upd  = ^{update_valid, update_pc, update_taken, update_target,
                         redirect_pc[1:0]};
`endif

  always_comb begin
    pc_next = pred_target;
    if (redirect_valid) pc_next = redirect_pc;
    else if (stall)     pc_next = pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= {RESET_PC[31:2], 2'b00};
    else       pc <= {pc_next[31:2], 2'b00};
  end

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Directed bench for ifu_pc_gen; BTB scenarios are selected when IFU_BTB_EN
// is defined, otherwise the no-BTB behaviour is checked.
module tb_ifu_pc_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  int n_cmp = 0;
  int n_err = 0;

  ifu_pc_gen #(.RESET_PC(32'h0000_3000), .BTB_ENTRIES(16)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target)
  );

  always #5 clk = ~clk;

  // Driver: hold the given inputs for one clock, then sample point is #1 after the edge.
  task automatic drive(input logic rv, input logic [31:0] rpc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic st);
    redirect_valid = rv; redirect_pc = rpc;
    update_valid = uv; update_pc = upc; update_taken = ut; update_target = utgt;
    stall = st;
    @(posedge clk); #1;
    redirect_valid = 1'b0; update_valid = 1'b0; stall = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (pc !== 32'h3000) begin n_err++; $display("FAIL reset_async pc=%h exp=%h", pc, 32'h3000); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred_taken got=%b exp=0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h3004) begin n_err++; $display("FAIL reset_pred_target got=%h exp=%h", pred_target, 32'h3004); end
    for (int k = 1; k <= 3; k++) begin
      idle();
      exp_pc = 32'h3000 + 32'(4 * k);
      n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL free_run_pc[%0d] got=%h exp=%h", k, pc, exp_pc); end
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL free_run_taken[%0d] got=%b exp=0", k, pred_taken); end
    end
  endtask

  task automatic test_redirect_stall();
    drive(1'b1, 32'h4003, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (pc !== 32'h4000) begin n_err++; $display("FAIL redirect_over_stall pc=%h exp=%h", pc, 32'h4000); end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      n_cmp++; if (pc !== 32'h4000) begin n_err++; $display("FAIL stall_hold[%0d] pc=%h exp=%h", k, pc, 32'h4000); end
    end
    n_cmp++; if (pred_target !== 32'h4004) begin n_err++; $display("FAIL stall_pred_target got=%h exp=%h", pred_target, 32'h4004); end
    idle();
    n_cmp++; if (pc !== 32'h4004) begin n_err++; $display("FAIL stall_release pc=%h exp=%h", pc, 32'h4004); end
  endtask

`ifdef IFU_BTB_EN
  task automatic test_train();
    drive(1'b1, 32'h3008, 1'b1, 32'h3010, 1'b1, 32'h3100, 1'b0);
    n_cmp++; if (pc !== 32'h3008 || pred_taken !== 1'b0) begin n_err++; $display("FAIL train_other_idx pc=%h taken=%b exp pc=3008 taken=0", pc, pred_taken); end
    idle(); idle();
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL train_hit_taken got=%b exp=1", pred_taken); end
    n_cmp++; if (pred_target !== 32'h3100) begin n_err++; $display("FAIL train_hit_target got=%h exp=%h", pred_target, 32'h3100); end
    idle();
    n_cmp++; if (pc !== 32'h3100) begin n_err++; $display("FAIL train_follow pc=%h exp=%h", pc, 32'h3100); end
    // Three not-taken updates: 10 -> 01 -> 00 -> 00.
    for (int k = 0; k < 3; k++) drive(1'b0, 32'h0, 1'b1, 32'h3010, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 32'h3010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h3014) begin n_err++; $display("FAIL ctr_floor taken=%b tgt=%h exp taken=0 tgt=3014", pred_taken, pred_target); end
    drive(1'b0, 32'h0, 1'b1, 32'h3010, 1'b1, 32'h3100, 1'b1);
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL ctr_00_to_01 taken=%b exp=0", pred_taken); end
    drive(1'b0, 32'h0, 1'b1, 32'h3010, 1'b1, 32'h3100, 1'b1);
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL ctr_01_to_10 taken=%b exp=1", pred_taken); end
    // 10 -> 11 -> 11, then one not-taken leaves 10 (still taken).
    for (int k = 0; k < 2; k++) drive(1'b0, 32'h0, 1'b1, 32'h3010, 1'b1, 32'h3100, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 32'h3010, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (pred_taken !== 1'b1 || pc !== 32'h3010) begin n_err++; $display("FAIL ctr_ceiling taken=%b pc=%h exp taken=1 pc=3010", pred_taken, pc); end
  endtask

  task automatic test_alias();
    drive(1'b0, 32'h0, 1'b1, 32'h3050, 1'b1, 32'h3200, 1'b1);
    n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h3014) begin n_err++; $display("FAIL alias_evict taken=%b tgt=%h exp taken=0 tgt=3014", pred_taken, pred_target); end
    drive(1'b1, 32'h3050, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h3200) begin n_err++; $display("FAIL alias_new taken=%b tgt=%h exp taken=1 tgt=3200", pred_taken, pred_target); end
  endtask

  task automatic test_same_cycle();
    update_valid = 1'b1; update_pc = 32'h3050; update_taken = 1'b1; update_target = 32'h3300;
    stall = 1'b1;
    #1;
    n_cmp++; if (pred_target !== 32'h3200) begin n_err++; $display("FAIL same_cycle_old tgt=%h exp=%h", pred_target, 32'h3200); end
    @(posedge clk); #1;
    update_valid = 1'b0; stall = 1'b0;
    n_cmp++; if (pc !== 32'h3050 || pred_target !== 32'h3300) begin n_err++; $display("FAIL same_cycle_new pc=%h tgt=%h exp pc=3050 tgt=3300", pc, pred_target); end
    idle();
    n_cmp++; if (pc !== 32'h3300) begin n_err++; $display("FAIL same_cycle_follow pc=%h exp=%h", pc, 32'h3300); end
  endtask
`else
  task automatic test_no_btb();
    drive(1'b1, 32'h3008, 1'b1, 32'h3010, 1'b1, 32'h3100, 1'b0);
    n_cmp++; if (pc !== 32'h3008) begin n_err++; $display("FAIL nobtb_redirect pc=%h exp=%h", pc, 32'h3008); end
    idle(); idle();
    n_cmp++; if (pc !== 32'h3010 || pred_taken !== 1'b0) begin n_err++; $display("FAIL nobtb_at_3010 pc=%h taken=%b exp pc=3010 taken=0", pc, pred_taken); end
    n_cmp++; if (pred_target !== 32'h3014) begin n_err++; $display("FAIL nobtb_target got=%h exp=%h", pred_target, 32'h3014); end
    idle();
    n_cmp++; if (pc !== 32'h3014) begin n_err++; $display("FAIL nobtb_next pc=%h exp=%h", pc, 32'h3014); end
  endtask
`endif

  task automatic test_wrap();
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (pc !== 32'hFFFF_FFFC || pred_taken !== 1'b0) begin n_err++; $display("FAIL wrap_load pc=%h taken=%b exp pc=fffffffc taken=0", pc, pred_taken); end
    n_cmp++; if (pred_target !== 32'h0) begin n_err++; $display("FAIL wrap_target got=%h exp=%h", pred_target, 32'h0); end
    idle();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
  endtask

  task automatic test_reset_midop();
    redirect_valid = 1'b1; redirect_pc = 32'h5000;
    update_valid = 1'b1; update_pc = 32'h3000; update_taken = 1'b1; update_target = 32'h3400;
    reset = 1'b1;
    #1;
    n_cmp++; if (pc !== 32'h3000) begin n_err++; $display("FAIL midop_async pc=%h exp=%h", pc, 32'h3000); end
    @(posedge clk); #1;
    redirect_valid = 1'b0; update_valid = 1'b0; reset = 1'b0;
    n_cmp++; if (pc !== 32'h3000 || pred_taken !== 1'b0) begin n_err++; $display("FAIL midop_discard pc=%h taken=%b exp pc=3000 taken=0", pc, pred_taken); end
    drive(1'b1, 32'h3050, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h3054) begin n_err++; $display("FAIL midop_btb_cleared taken=%b tgt=%h exp taken=0 tgt=3054", pred_taken, pred_target); end
    idle();
    n_cmp++; if (pc !== 32'h3054) begin n_err++; $display("FAIL midop_resume pc=%h exp=%h", pc, 32'h3054); end
  endtask

  initial begin
    test_reset();
    test_redirect_stall();
`ifdef IFU_BTB_EN
    test_train();
    test_alias();
    test_same_cycle();
`else
    test_no_btb();
`endif
    test_wrap();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
